// File: rtl/router_pkg.sv
// Shared router definitions: flit width, header field positions and direction encoding.
// Used by both the 5-way arbiter-merge stage and the XY route-split stage.
package router_pkg;
    localparam int FLIT_W    = 32;
    localparam int NUM_DIR   = 5;
    localparam int DST_X_MSB = 31;
    localparam int DST_X_LSB = 28;
    localparam int DST_Y_MSB = 27;
    localparam int DST_Y_LSB = 24;

    typedef enum logic [2:0] {
        DIR_WEST  = 3'd0,
        DIR_EAST  = 3'd1,
        DIR_NORTH = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_LOCAL = 3'd4
    } dir_e;
endpackage

// File: rtl/xy_route_calc.sv
// Dimension-order (X first, then Y) route computation -> one-hot direction.
module xy_route_calc
    import router_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int LOCAL_X = 1,
    parameter int LOCAL_Y = 1
) (
    input  logic [COORD_W-1:0] dst_x,
    input  logic [COORD_W-1:0] dst_y,
    output logic [NUM_DIR-1:0] dir_5
);
    localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);

    // Resolve X offset fully before looking at Y; unsigned compares throughout.
    always_comb begin
        dir_5 = '0;
        if (dst_x > LX)      dir_5[DIR_EAST]  = 1'b1;
        else if (dst_x < LX) dir_5[DIR_WEST]  = 1'b1;
        else if (dst_y > LY) dir_5[DIR_NORTH] = 1'b1;
        else if (dst_y < LY) dir_5[DIR_SOUTH] = 1'b1;
        else                 dir_5[DIR_LOCAL] = 1'b1;
    end
endmodule

// File: rtl/xy_route_split_32b.sv
// XY route-split stage: routes each incoming flit into a small FIFO tagged with its
// one-hot direction and presents the head flit on exactly one of five outputs.
// Optional build macro STATS_EN adds five saturating per-direction pop counters.
module xy_route_split_32b
    import router_pkg::*;
#(
    parameter int LOCAL_X = 1,
    parameter int LOCAL_Y = 1,
    parameter int COORD_W = 4,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [FLIT_W-1:0]  i_data_32,
    output logic [NUM_DIR-1:0] o_valid_5,
    input  logic [NUM_DIR-1:0] i_ready_5,
    output logic [FLIT_W-1:0]  o_data_32
`ifdef STATS_EN
   ,input  logic [2:0]         o_stat_sel,
    output logic [15:0]        o_stat_cnt_16
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [FLIT_W-1:0]  mem_data [DEPTH];
    logic [NUM_DIR-1:0] mem_dir  [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [FLIT_W-1:0]  last_data;
    logic [NUM_DIR-1:0] in_dir;
    logic [NUM_DIR-1:0] head_dir;
    logic               push, pop;

    xy_route_calc #(
        .COORD_W (COORD_W),
        .LOCAL_X (LOCAL_X),
        .LOCAL_Y (LOCAL_Y)
    ) u_calc (
        .dst_x (i_data_32[DST_X_LSB +: COORD_W]),
        .dst_y (i_data_32[DST_Y_LSB +: COORD_W]),
        .dir_5 (in_dir)
    );

    // Ready depends only on occupancy, so a full FIFO refuses a push even while popping.
    assign o_ready   = (count < CNT_W'(DEPTH));
    assign head_dir  = (count != '0) ? mem_dir[rd_ptr] : '0;
    assign o_valid_5 = head_dir;
    // When empty, keep showing the most recently popped flit rather than stale storage.
    assign o_data_32 = (count != '0) ? mem_data[rd_ptr] : last_data;
    assign push      = i_valid & o_ready;
    assign pop       = |(head_dir & i_ready_5);

    // FIFO storage, pointers, occupancy and last-popped data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_dir[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= i_data_32;
                mem_dir[wr_ptr]  <= in_dir;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                last_data <= mem_data[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef STATS_EN
    logic [15:0] stat_cnt [NUM_DIR];

    // Per-direction pop counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < NUM_DIR; d++) stat_cnt[d] <= '0;
        end else if (pop) begin
            for (int d = 0; d < NUM_DIR; d++)
                if (head_dir[d] && stat_cnt[d] != 16'hFFFF) stat_cnt[d] <= stat_cnt[d] + 16'd1;
        end
    end

    // Counter readout; out-of-range selects read as zero.
    always_comb begin
        o_stat_cnt_16 = '0;
        for (int d = 0; d < NUM_DIR; d++)
            if (o_stat_sel == 3'(d)) o_stat_cnt_16 = stat_cnt[d];
    end
`endif
endmodule

// File: tb/tb_xy_route_split_32b.sv
// Directed bench for xy_route_split_32b (LOCAL_X=1, LOCAL_Y=1, DEPTH=2).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_xy_route_split_32b;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data_32;
    logic [4:0]  o_valid_5;
    logic [4:0]  i_ready_5;
    logic [31:0] o_data_32;
`ifdef STATS_EN
    logic [2:0]  o_stat_sel;
    logic [15:0] o_stat_cnt_16;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xy_route_split_32b #(.LOCAL_X(1), .LOCAL_Y(1), .COORD_W(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data_32 (i_data_32),
        .o_valid_5 (o_valid_5),
        .i_ready_5 (i_ready_5),
        .o_data_32 (o_data_32)
`ifdef STATS_EN
       ,.o_stat_sel    (o_stat_sel),
        .o_stat_cnt_16 (o_stat_cnt_16)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [31:0] vec  [5] = '{32'h2100_00AA, 32'h0100_00BB, 32'h1200_00CC, 32'h1000_00DD, 32'h1100_00EE};
    logic [4:0]  vdir [5] = '{5'b00010, 5'b00001, 5'b00100, 5'b01000, 5'b10000};

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_data_32 = '0; i_ready_5 = '0;
`ifdef STATS_EN
        o_stat_sel = 3'd0;
`endif
        cyc();
        chk("rst_valid", 32'(o_valid_5), 32'h0);
        chk("rst_data",  o_data_32, 32'h0);
        chk("rst_ready", 32'(o_ready), 32'h1);
        rst = 1'b1;
        cyc();

        // Each direction, one flit at a time, downstream always ready.
        i_ready_5 = 5'h1F;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1; i_data_32 = vec[k];
            cyc();
            chk($sformatf("route_valid%0d", k), 32'(o_valid_5), 32'(vdir[k]));
            chk($sformatf("route_data%0d", k),  o_data_32, vec[k]);
            i_valid = 1'b0;
            cyc();
            chk($sformatf("popped_valid%0d", k), 32'(o_valid_5), 32'h0);
            chk($sformatf("hold_data%0d", k),    o_data_32, vec[k]);
        end

        // Back-to-back pushes with downstream stalled; third is held off.
        i_ready_5 = 5'h00;
        i_valid = 1'b1; i_data_32 = 32'h2100_0001;
        cyc();
        chk("fill1_ready", 32'(o_ready), 32'h1);
        i_data_32 = 32'h2100_0002;
        cyc();
        chk("fill2_ready", 32'(o_ready), 32'h0);
        chk("fill2_valid", 32'(o_valid_5), 32'h02);
        chk("fill2_data",  o_data_32, 32'h2100_0001);
        i_data_32 = 32'h2100_0003;
        cyc();
        chk("held_ready", 32'(o_ready), 32'h0);
        chk("held_data",  o_data_32, 32'h2100_0001);
        i_ready_5 = 5'b00010;
        cyc();
        chk("unblock_ready", 32'(o_ready), 32'h1);
        chk("unblock_data",  o_data_32, 32'h2100_0002);
        cyc();
        chk("pushpop_data",  o_data_32, 32'h2100_0003);
        chk("pushpop_ready", 32'(o_ready), 32'h1);
        i_valid = 1'b0;
        cyc();
        chk("drain3_valid", 32'(o_valid_5), 32'h0);

        // Full FIFO with a pop in the same cycle: push refused, accepted next cycle.
        i_ready_5 = 5'h00;
        i_valid = 1'b1; i_data_32 = 32'h0100_0004;
        cyc();
        i_data_32 = 32'h0100_0005;
        cyc();
        chk("full_ready", 32'(o_ready), 32'h0);
        i_data_32 = 32'h0100_0006; i_ready_5 = 5'b00001;
        cyc();
        chk("fullpop_ready", 32'(o_ready), 32'h1);
        chk("fullpop_data",  o_data_32, 32'h0100_0005);
        i_ready_5 = 5'h00;
        cyc();
        chk("refill_ready", 32'(o_ready), 32'h0);
        chk("refill_data",  o_data_32, 32'h0100_0005);
        i_valid = 1'b0; i_ready_5 = 5'h1F;
        cyc();
        chk("drain4a_data",  o_data_32, 32'h0100_0006);
        chk("drain4a_valid", 32'(o_valid_5), 32'h01);
        cyc();
        chk("drain4b_valid", 32'(o_valid_5), 32'h0);

        // Ready on every direction except the head's: no pop.
        i_ready_5 = 5'b11101;
        i_valid = 1'b1; i_data_32 = 32'h3100_0007;
        cyc();
        i_valid = 1'b0;
        chk("hol_valid", 32'(o_valid_5), 32'h02);
        cyc();
        chk("hol_valid2", 32'(o_valid_5), 32'h02);
        chk("hol_data2",  o_data_32, 32'h3100_0007);
        chk("hol_ready2", 32'(o_ready), 32'h1);
        i_ready_5 = 5'h1F;
        cyc();
        chk("hol_pop_valid", 32'(o_valid_5), 32'h0);

`ifdef STATS_EN
        o_stat_sel = 3'd1;
        #1 chk("stat_east", 32'(o_stat_cnt_16), 32'd5);
        o_stat_sel = 3'd0;
        #1 chk("stat_west", 32'(o_stat_cnt_16), 32'd4);
        o_stat_sel = 3'd4;
        #1 chk("stat_local", 32'(o_stat_cnt_16), 32'd1);
`endif

        // Reset while holding two flits.
        i_ready_5 = 5'h00;
        i_valid = 1'b1; i_data_32 = 32'h1100_0008;
        cyc();
        i_data_32 = 32'h1100_0009;
        cyc();
        i_valid = 1'b0;
        chk("pre_rst_ready", 32'(o_ready), 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid_5), 32'h0);
        chk("mid_rst_data",  o_data_32, 32'h0);
        chk("mid_rst_ready", 32'(o_ready), 32'h1);
`ifdef STATS_EN
        chk("mid_rst_stat", 32'(o_stat_cnt_16), 32'h0);
`endif
        cyc();
        rst = 1'b1;
        cyc();
        chk("post_rst_ready", 32'(o_ready), 32'h1);
        chk("post_rst_valid", 32'(o_valid_5), 32'h0);

`ifdef STATS_EN
        // Saturation of the local counter.
        i_ready_5 = 5'h1F;
        i_valid = 1'b1; i_data_32 = 32'h1100_0000;
        repeat (70000) cyc();
        i_valid = 1'b0;
        repeat (3) cyc();
        o_stat_sel = 3'd4;
        #1 chk("stat_sat", 32'(o_stat_cnt_16), 32'h0000_FFFF);
        o_stat_sel = 3'd5;
        #1 chk("stat_sel5", 32'(o_stat_cnt_16), 32'h0);
        o_stat_sel = 3'd0;
        #1 chk("stat_sel0", 32'(o_stat_cnt_16), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
